// File: rtl/note_sequencer.sv
// Note-table sequencer: plays a programmed list of (frequency, duration) entries
// and drives frequency_control / tone_en of a downstream square-wave generator.
module note_sequencer #(
    parameter int DEPTH    = 8,
    parameter int DUR_W    = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_freq,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic [$clog2(DEPTH)-1:0] last_idx,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic [7:0]               frequency_control,
    output logic                     tone_en,
    output logic [$clog2(DEPTH)-1:0] note_idx,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t           state_q, state_d;
    logic [7:0]       freq_tbl_q [DEPTH];
    logic [7:0]       freq_tbl_d [DEPTH];
    logic [DUR_W-1:0] dur_tbl_q  [DEPTH];
    logic [DUR_W-1:0] dur_tbl_d  [DEPTH];
    logic [AW-1:0]    idx_q, idx_d, last_q, last_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [7:0]       freq_q, freq_d;
    logic             tone_q, tone_d;
    logic             done_q, done_d;
    logic             go_idle;
    logic             tick;
    logic [7:0]       rd_freq;
    logic [DUR_W-1:0] rd_dur;

    // Registered table: the LOAD read sees the contents before any same-cycle write.
    assign rd_freq = freq_tbl_q[idx_q];
    assign rd_dur  = dur_tbl_q[idx_q];
    assign tick    = (pre_q == PRE_LAST);

    always_comb begin
        freq_tbl_d = freq_tbl_q;
        dur_tbl_d  = dur_tbl_q;
        if (wr_en) begin
            freq_tbl_d[wr_addr] = wr_freq;
            dur_tbl_d[wr_addr]  = wr_dur;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        freq_d  = freq_q;
        tone_d  = tone_q;
        done_d  = 1'b0;
        go_idle = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    last_d  = last_idx;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else begin
                    cnt_d   = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
                    pre_d   = '0;
                    freq_d  = rd_freq;
                    tone_d  = (rd_freq != 8'd0);
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        if (cnt_q == DUR_W'(1)) begin
                            if (idx_q != last_q) begin
                                idx_d   = idx_q + 1'b1;
                                state_d = LOAD;
                            end else if (loop) begin
                                idx_d   = '0;
                                state_d = LOAD;
                            end else begin
                                go_idle = 1'b1;
                                done_d  = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (go_idle) begin
            state_d = IDLE;
            freq_d  = 8'd0;
            tone_d  = 1'b0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            freq_tbl_q <= '{default: '0};
            dur_tbl_q  <= '{default: '0};
            idx_q      <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            freq_q     <= 8'd0;
            tone_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            freq_tbl_q <= freq_tbl_d;
            dur_tbl_q  <= dur_tbl_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            freq_q     <= freq_d;
            tone_q     <= tone_d;
            done_q     <= done_d;
        end
    end

    assign frequency_control = freq_q;
    assign tone_en           = tone_q;
    assign note_idx          = idx_q;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a note-level playback model predicts the per-cycle
// output vector {busy, done, tone_en, note_idx, frequency_control}.
module tb_note_sequencer;
    localparam int DEPTH = 8;
    localparam int DUR_W = 16;
    localparam int TDIV  = 4;
    localparam int W     = 14;

    logic             clk;
    logic             reset_n;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [7:0]       wr_freq;
    logic [DUR_W-1:0] wr_dur;
    logic [2:0]       last_idx;
    logic             start;
    logic             stop;
    logic             loop;
    logic [7:0]       frequency_control;
    logic             tone_en;
    logic [2:0]       note_idx;
    logic             busy;
    logic             done;

    logic [W-1:0] exp_q[$];
    int           m_freq [DEPTH];
    int           m_dur  [DEPTH];
    int           checks;
    int           errors;
    int           pw_addr, pw_freq, pw_dur;

    note_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TDIV)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_freq(wr_freq), .wr_dur(wr_dur), .last_idx(last_idx),
        .start(start), .stop(stop), .loop(loop),
        .frequency_control(frequency_control), .tone_en(tone_en),
        .note_idx(note_idx), .busy(busy), .done(done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input bit b, input bit d, input bit t,
                                          input int idx, input int f);
        logic [2:0] i3;
        logic [7:0] f8;
        i3 = idx[2:0];
        f8 = f[7:0];
        return {b, d, t, i3, f8};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {busy, done, tone_en, note_idx, frequency_control};
    endfunction

    // Playback model: cycle 0 is the cycle start is presented; each note is one
    // LOAD cycle holding the previous sound, then max(dur,1)*TDIV sounding cycles.
    function automatic void model_run(input int last, input bit lp,
                                      input int stop_cyc, input int abort_cyc);
        logic [W-1:0] tr[$];
        int idx = 0;
        int pf  = 0;
        int f, n;
        tr.push_back(pack(0, 0, 0, 0, 0));
        while (tr.size() < 5000) begin
            tr.push_back(pack(1, 0, pf != 0, idx, pf));
            f = m_freq[idx];
            n = ((m_dur[idx] == 0) ? 1 : m_dur[idx]) * TDIV;
            for (int k = 0; k < n; k++) tr.push_back(pack(1, 0, f != 0, idx, f));
            pf = f;
            if (idx == last) begin
                if (lp) idx = 0;
                else begin
                    tr.push_back(pack(0, 1, 0, 0, 0));
                    tr.push_back(pack(0, 0, 0, 0, 0));
                    break;
                end
            end else begin
                idx++;
            end
        end
        for (int c = 0; c < tr.size(); c++) begin
            if (c == abort_cyc) break;
            exp_q.push_back(tr[c]);
            if (c == stop_cyc) begin
                exp_q.push_back(pack(0, 0, 0, 0, 0));
                break;
            end
        end
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e, a;
            e = exp_q.pop_front();
            a = dut_vec();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_vec t=%0t got busy=%0b done=%0b tone=%0b idx=%0d freq=%0d expected busy=%0b done=%0b tone=%0b idx=%0d freq=%0d",
                         $time, a[13], a[12], a[11], a[10:8], a[7:0],
                         e[13], e[12], e[11], e[10:8], e[7:0]);
            end
        end
    end

    // driver tasks
    task automatic write_entry(input int a, input int f, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_freq = 8'(f); wr_dur = DUR_W'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_freq[a] = f;
        m_dur[a]  = d;
    endtask

    task automatic run_seq(input int last, input bit lp, input int stop_cyc,
                           input int abort_cyc, input int restart_cyc, input int wr_cyc);
        int n;
        if (wr_cyc >= 0) begin
            m_freq[pw_addr] = pw_freq;
            m_dur[pw_addr]  = pw_dur;
        end
        model_run(last, lp, stop_cyc, abort_cyc);
        n = exp_q.size();
        loop = lp;
        for (int c = 0; c < n; c++) begin
            last_idx = (c == 0) ? 3'(last) : 3'($urandom_range(0, 7));
            start    = (c == 0) || (c == restart_cyc);
            stop     = (c == stop_cyc);
            wr_en    = (c == wr_cyc);
            wr_addr  = 3'(pw_addr);
            wr_freq  = 8'(pw_freq);
            wr_dur   = DUR_W'(pw_dur);
            @(posedge clk); #1;
        end
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero_now(input string name);
        checks++;
        if (dut_vec() !== pack(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, dut_vec(), pack(0, 0, 0, 0, 0));
        end
    endtask

    initial begin
        int last, stop_c, restart_c, wr_c;
        bit lp;
        checks = 0; errors = 0;
        reset_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0;
        last_idx = '0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        pw_addr = 0; pw_freq = 0; pw_dur = 0;
        for (int i = 0; i < DEPTH; i++) begin m_freq[i] = 0; m_dur[i] = 0; end

        // asynchronous reset before any clock edge
        #2 reset_n = 1'b0;
        #1 check_zero_now("reset_async");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // basic program, no loop
        write_entry(0, 10, 2);
        write_entry(1, 20, 1);
        write_entry(2, 0, 3);
        run_seq(2, 0, -1, -1, -1, -1);
        // looping: replays note 0 after note 2, stopped later
        run_seq(2, 1, 32, -1, -1, -1);
        // stop at third PLAY cycle of note 0
        run_seq(2, 0, 4, -1, -1, -1);
        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        repeat (4) exp_q.push_back(pack(0, 0, 0, 0, 0));
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        // dur=0 entry and rewrite of the next entry during PLAY
        write_entry(0, 5, 0);
        write_entry(1, 7, 2);
        pw_addr = 1; pw_freq = 9; pw_dur = 1;
        run_seq(1, 0, -1, -1, -1, 3);

        // randomized programs
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < DEPTH; i++)
                write_entry(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                            $urandom_range(0, 3));
            last = $urandom_range(0, 7);
            lp = ($urandom_range(0, 2) == 0);
            stop_c = -1; restart_c = -1; wr_c = -1;
            if (lp) stop_c = $urandom_range(6, 150);
            else if ($urandom_range(0, 3) == 0) stop_c = $urandom_range(1, 5);
            else restart_c = 3;
            if ($urandom_range(0, 1) == 1) begin
                wr_c = $urandom_range(2, 5);
                pw_addr = $urandom_range(1, 7);
                pw_freq = $urandom_range(0, 255);
                pw_dur  = $urandom_range(0, 3);
            end
            run_seq(last, lp, stop_c, -1, restart_c, wr_c);
        end

        // reset in the middle of PLAY, then table must read back as cleared
        write_entry(0, 33, 2);
        write_entry(1, 44, 1);
        run_seq(1, 0, -1, 4, -1, -1);
        #2 reset_n = 1'b0;
        #1 check_zero_now("reset_mid_play");
        for (int i = 0; i < DEPTH; i++) begin m_freq[i] = 0; m_dur[i] = 0; end
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        run_seq(2, 0, -1, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of note-table entries (power of 2, >=2).
REQ-002 SHALL have parameter DUR_W, default 16, width of per-note duration in ticks.
REQ-003 SHALL have parameter TICK_DIV, default 1000, clock cycles per duration tick (>=1).
REQ-004 SHALL have these ports, one per line; AW = log2(DEPTH):
  clk  in  1  sole clock, rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  wr_en  in  1  table write strobe.
  wr_addr  in  AW  table write index.
  wr_freq  in  8  note frequency_control value; 0 = rest.
  wr_dur  in  DUR_W  note duration in ticks.
  last_idx  in  AW  index of final note in the sequence.
  start  in  1  begin playback (pulse).
  stop  in  1  abort playback (pulse).
  loop  in  1  level; repeat the sequence after the last note.
  frequency_control  out  8  registered; drives square_wave.frequency_control.
  tone_en  out  1  registered; high while a non-rest note sounds.
  note_idx  out  AW  index of the current note.
  busy  out  1  high in LOAD or PLAY.
  done  out  1  one-cycle pulse at natural sequence end.

Function
REQ-005 SHALL hold a DEPTH x (8+DUR_W) table; wr_en writes {wr_freq,wr_dur} to wr_addr at the clock edge, in any state.
REQ-006 SHALL read the table before writing, so a same-cycle write to the entry being loaded takes effect only on the next load of that entry.
REQ-007 SHALL implement states IDLE, LOAD, PLAY.
REQ-008 IDLE: start=1 and stop=0 -> latch last_idx, note_idx<=0, go to LOAD.
REQ-009 LOAD (1 cycle): read entry note_idx; load duration counter with max(dur,1); clear prescaler; go to PLAY. At the same edge frequency_control<=freq and tone_en<=(freq!=0).
REQ-010 During LOAD, frequency_control and tone_en SHALL hold their previous values (0 on the first LOAD from IDLE).
REQ-011 PLAY: prescaler counts 0..TICK_DIV-1 and wraps; tick = (prescaler==TICK_DIV-1); each tick decrements the duration counter.
REQ-012 PLAY: tick with counter==1 ends the note -> not last: note_idx+1 then LOAD; last with loop=1: note_idx<=0 then LOAD; last with loop=0: IDLE, done=1 for one cycle.
REQ-013 Each note SHALL last exactly 1 LOAD cycle + max(dur,1)*TICK_DIV PLAY cycles.
REQ-014 loop SHALL be sampled at the end of the last note; last_idx only at start.
REQ-015 start while busy SHALL be ignored.
REQ-016 stop in LOAD or PLAY SHALL go to IDLE at the next edge, with no done pulse; stop overrides start and note advance in the same cycle.
REQ-017 On entering IDLE (stop or natural end), frequency_control<=0, tone_en<=0, note_idx<=0.
REQ-018 busy SHALL be 1 in LOAD and PLAY, else 0; done SHALL never assert together with busy=1.

Reset
REQ-019 reset_n=0 SHALL immediately and asynchronously force IDLE and set all outputs, counters, latched last_idx and every table entry to 0.
REQ-020 After reset_n deassertion, the block SHALL wait in IDLE for start.

Verification (TICK_DIV=4, DEPTH=8, DUR_W=16)
REQ-021 Reset: assert reset_n=0 -> frequency_control=0, tone_en=0, busy=0, done=0, note_idx=0 without any clock edge.
REQ-022 Program (10,2),(20,1),(0,3); last_idx=2; loop=0; pulse start -> LOAD, then freq 10/tone_en 1 for 8 cycles, LOAD, freq 20 for 4 cycles, LOAD, freq 0/tone_en 0 for 12 cycles, then done=1 for one cycle, busy=0, outputs 0.
REQ-023 Same program with loop=1 -> after note 2, note_idx=0 and freq 10 again; done never pulses.
REQ-024 stop at PLAY cycle 3 of note 0 -> next cycle busy=0, frequency_control=0, no done; start+stop in the same IDLE cycle -> stays IDLE.
REQ-025 Entry with dur=0 -> plays 1 tick (4 PLAY cycles); write to the next entry during PLAY of the current one -> new value is played.
REQ-026 reset_n low mid-PLAY -> outputs 0 asynchronously; after release, start plays freq 0 (table cleared) with tone_en=0.
